// File: rtl/cb_param.sv
// rtl/cb_param.sv - parametrised connection block with serial daisy-chain config and shadow/commit stage
// Optional feature macro: CB_PARITY_EN (adds one even-parity bit to the chain and checks it at commit).
module cb_param #(
    parameter int CHAN_W = 4,
    parameter int SIDES  = 4
) (
    input  logic                     clb_clk,
    input  logic                     rst,
    input  logic                     prog_in,
    input  logic                     prog_en,
    output logic                     prog_out,
    output logic                     cfg_valid,
    output logic                     cfg_err,
    input  logic [SIDES*CHAN_W-1:0]  in_bus,
    output logic [SIDES*CHAN_W-1:0]  out_bus
);

    localparam int NTRK    = SIDES * CHAN_W;
    localparam int NSRC    = (SIDES - 1) * CHAN_W;
    localparam int SEL_W   = $clog2(NSRC + 1);
    localparam int FW      = SEL_W + 1;
    localparam int CFG_LEN = NTRK * FW;
    localparam int NCAND   = 1 << SEL_W;
`ifdef CB_PARITY_EN
    localparam int LEN     = CFG_LEN + 1;
`else
    localparam int LEN     = CFG_LEN;
`endif
    localparam int CNT_W   = $clog2(LEN + 2);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [LEN-1:0]      r_sr;
    logic [CFG_LEN-1:0]  r_active;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                r_valid;
    logic                r_err;
    logic [NTRK-1:0]     r_out_q;
    logic                w_shift;
    logic                w_commit;
    logic                w_reject;
    logic                w_parity_ok;
    logic [CFG_LEN-1:0]  w_sr_cfg;
    logic [NTRK-1:0]     w_mux;
    logic [NTRK-1:0]     w_reg_en;

`ifdef CB_PARITY_EN
    // Parity bit is the last one shifted in and is not part of the routing image.
    assign w_parity_ok = ~(^r_sr);
    assign w_sr_cfg    = r_sr[CFG_LEN-1:0];
`else
    assign w_parity_ok = 1'b1;
    assign w_sr_cfg    = r_sr;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift     = 1'b0;
        w_commit    = 1'b0;
        w_reject    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (prog_en) begin
                    w_shift     = 1'b1;
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (prog_en) begin
                    w_shift = 1'b1;
                    if (r_cnt != CNT_W'(LEN + 1)) begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end else begin
                    w_state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if ((r_cnt == CNT_W'(LEN)) && w_parity_ok) begin
                    w_commit = 1'b1;
                end else begin
                    w_reject = 1'b1;
                end
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clb_clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Routing only ever changes from the shadow copy, so shifting never disturbs out_bus.
    always_ff @(posedge clb_clk or negedge rst) begin
        if (!rst) begin
            r_sr     <= '0;
            r_active <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_shift) begin
                r_sr <= {prog_in, r_sr[LEN-1:1]};
            end
            if (w_commit) begin
                r_active <= w_sr_cfg;
                r_valid  <= 1'b1;
                r_err    <= 1'b0;
            end else if (w_reject) begin
                r_err    <= 1'b1;
            end
        end
    end

    // Candidate k of track j: k=0 and k>NSRC are constant 0; otherwise walk the other sides in order.
    for (genvar j = 0; j < NTRK; j++) begin : g_trk
        localparam int S = j / CHAN_W;
        logic [NCAND-1:0] w_cand;
        logic [SEL_W-1:0] w_sel;

        for (genvar k = 0; k < NCAND; k++) begin : g_src
            if ((k >= 1) && (k <= NSRC)) begin : g_on
                assign w_cand[k] = in_bus[((S + 1 + (k - 1) / CHAN_W) % SIDES) * CHAN_W + (k - 1) % CHAN_W];
            end else begin : g_off
                assign w_cand[k] = 1'b0;
            end
        end

        assign w_sel       = r_active[j*FW +: SEL_W];
        assign w_reg_en[j] = r_active[j*FW + SEL_W];
        assign w_mux[j]    = w_cand[w_sel];
        assign out_bus[j]  = w_reg_en[j] ? r_out_q[j] : w_mux[j];
    end

    always_ff @(posedge clb_clk or negedge rst) begin
        if (!rst) begin
            r_out_q <= '0;
        end else begin
            r_out_q <= w_mux;
        end
    end

    assign prog_out  = r_sr[0];
    assign cfg_valid = r_valid;
    assign cfg_err   = r_err;

endmodule
